// File: rtl/popcount_frame_scheduler.sv
// Round-robin, frame-granular arbiter sharing one 127-bit popcount pipeline.
// Each frame's popcount total is returned with the winning requester's id.
module popcount_frame_scheduler #(
    parameter int NREQ      = 4,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*127-1:0]   req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_W-1:0]      res_count,
    output logic [2:0]            res_id,
    output logic                  res_overflow,
    output logic                  busy
);

    localparam int W  = 127;
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

    state_t             state, state_n;
    logic [GW-1:0]      grant, rr_ptr, pick, idx;
    logic               pick_v;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W:0]     sum;
    logic               ovf;
    logic [BW-1:0]      beats;
    logic [6:0]         pc_q, pc_d;
    logic               pc_v;
    logic               drain_cnt;
    logic               res_valid_q;
    logic               accept;
    logic [W-1:0]       word;
    logic [W-1:0]       words [NREQ];

    function automatic logic [6:0] ones(input logic [W-1:0] v);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < W; i++) s = s + {6'b0, v[i]};
        return s;
    endfunction

    for (genvar k = 0; k < NREQ; k++) begin : g_words
        assign words[k] = req_data[k*W +: W];
    end

    // First asserted requester after the last winner, wrapping modulo NREQ
    always_comb begin
        pick   = '0;
        pick_v = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(rr_ptr) + i) % NREQ);
            if (!pick_v && req_valid[idx]) begin
                pick   = idx;
                pick_v = 1'b1;
            end
        end
    end

    assign word   = words[grant];
    assign pc_d   = ones(word);
    assign accept = (state == STREAM) && req_valid[grant];
    assign sum    = {1'b0, acc} + (CNT_W+1)'(pc_q);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (pick_v) state_n = STREAM;
            STREAM: if (accept && req_last[grant]) state_n = DRAIN;
            DRAIN:  if (drain_cnt) state_n = RESULT;
            RESULT: if (res_valid_q && res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= GW'(NREQ - 1);
            grant       <= '0;
            acc         <= '0;
            beats       <= '0;
            ovf         <= 1'b0;
            pc_q        <= '0;
            pc_v        <= 1'b0;
            drain_cnt   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            pc_v        <= accept;
            drain_cnt   <= (state == DRAIN) ? !drain_cnt : 1'b0;
            res_valid_q <= (state == RESULT) && !(res_valid_q && res_ready);
            if (accept) pc_q <= pc_d;
            if (state == IDLE && pick_v) begin
                grant  <= pick;
                rr_ptr <= pick;
                acc    <= '0;
                beats  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (pc_v) begin
                    acc <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                    if (sum[CNT_W]) ovf <= 1'b1;
                end
                // Beat counter parks at MAX_WORDS; any further beat flags overflow
                if (accept) begin
                    if (beats == BW'(MAX_WORDS)) ovf <= 1'b1;
                    else beats <= beats + BW'(1);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == STREAM) req_ready[grant] = 1'b1;
    end

    assign busy         = (state != IDLE);
    assign res_valid    = res_valid_q;
    assign res_count    = res_valid_q ? acc : '0;
    assign res_id       = res_valid_q ? 3'(grant) : 3'd0;
    assign res_overflow = res_valid_q & ovf;

endmodule

// File: tb/tb_popcount_frame_scheduler.sv
// Directed bench for popcount_frame_scheduler: frames, arbitration order,
// saturation, result back-pressure and mid-frame reset.
module tb_popcount_frame_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_last;
    logic [507:0]  req_data;
    logic [3:0]    req_ready;
    logic          res_valid;
    logic          res_ready;
    logic [10:0]   res_count;
    logic [2:0]    res_id;
    logic          res_overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int other_hits = 0;
    logic mon_en = 1'b0;
    logic [3:0] mon_mask = 4'b0;
    logic [126:0] all1 = {127{1'b1}};

    popcount_frame_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_id(res_id),
        .res_overflow(res_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && ((req_ready & mon_mask) != 4'b0)) other_hits++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int k, input logic [126:0] d,
                             input logic last);
        int n;
        req_valid[k] = 1'b1;
        req_last[k]  = last;
        req_data[k*127 +: 127] = d;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
        step();
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        chk("res_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_drop", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int c;
        int n;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(res_count), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_ovf", 32'(res_overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single all-ones beat from req0, latency measured from accept edge
        send_word(0, all1, 1'b1);
        c = 0;
        do begin
            step();
            c++;
        end while (!res_valid && c < 20);
        chk("t1_latency", 32'(c), 32'd3);
        chk("t1_count", 32'(res_count), 32'd127);
        chk("t1_id", 32'(res_id), 32'd0);
        chk("t1_ovf", 32'(res_overflow), 32'd0);
        handshake();

        // req2 three words; req1/req3 contend mid-frame
        send_word(2, 127'h1, 1'b0);
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        mon_mask = 4'b1010;
        mon_en = 1'b1;
        send_word(2, 127'hFF, 1'b0);
        send_word(2, 127'h0, 1'b1);
        wait_res();
        chk("t2_count", 32'(res_count), 32'd9);
        chk("t2_id", 32'(res_id), 32'd2);
        chk("t2_ovf", 32'(res_overflow), 32'd0);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b0;
        mon_en = 1'b0;
        chk("t2_others", 32'(other_hits), 32'd0);
        handshake();

        // req1: 17 all-ones words -> beat overflow and saturation
        for (int i = 0; i < 17; i++) send_word(1, all1, i == 16);
        wait_res();
        chk("t4_count", 32'(res_count), 32'd2047);
        chk("t4_id", 32'(res_id), 32'd1);
        chk("t4_ovf", 32'(res_overflow), 32'd1);
        handshake();

        // req3 frame with result back-pressure
        send_word(3, 127'h3, 1'b0);
        send_word(3, 127'h7, 1'b1);
        wait_res();
        req_valid[0] = 1'b1;
        req_last[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", 32'(res_valid), 32'd1);
            chk("t5_count", 32'(res_count), 32'd5);
            chk("t5_id", 32'(res_id), 32'd3);
            chk("t5_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid[0] = 1'b0;
        req_last[0] = 1'b0;
        handshake();
        step();

        // all requesters valid: grant order 0,1,2,3,0
        res_ready = 1'b1;
        req_valid = 4'hF;
        req_last = 4'hF;
        for (int k = 0; k < 4; k++) req_data[k*127 +: 127] = 127'h1 << k;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (req_ready == 4'b0 && n < 50) begin
                step();
                n++;
            end
            chk("t3_grant", 32'(req_ready), 32'(1 << (f % 4)));
            wait_res();
            chk("t3_id", 32'(res_id), 32'(f % 4));
            chk("t3_count", 32'(res_count), 32'd1);
            if (f == 4) begin
                req_valid = '0;
                req_last = '0;
            end
            step();
        end
        res_ready = 1'b0;
        repeat (3) step();
        chk("t3_idle", 32'(busy), 32'd0);

        // reset during 2nd beat of a 4-beat frame
        send_word(2, all1, 1'b0);
        req_valid[2] = 1'b1;
        req_data[2*127 +: 127] = all1;
        rst = 1'b1;
        step();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_valid", 32'(res_valid), 32'd0);
        chk("t6_count", 32'(res_count), 32'd0);
        chk("t6_ovf", 32'(res_overflow), 32'd0);
        rst = 1'b0;
        req_valid[2] = 1'b0;
        repeat (6) step();
        chk("t6_nores", 32'(res_valid), 32'd0);
        send_word(0, 127'hF, 1'b1);
        wait_res();
        chk("t6_count2", 32'(res_count), 32'd4);
        chk("t6_id2", 32'(res_id), 32'd0);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
